// File: rtl/acq_bram_ctrl.sv
// acq_bram_ctrl: ADC stream capture into a to-host BRAM port.
// Arm latches length/decimation, trigger starts a linear capture from address 0.
module acq_bram_ctrl #(
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 64,
    parameter int DECIM_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   trig,
    input  logic [ADDR_WIDTH:0]    length,
    input  logic [DECIM_WIDTH-1:0] decim,
    input  logic [DATA_WIDTH-1:0]  s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [ADDR_WIDTH-1:0]  bram_addr,
    output logic [DATA_WIDTH-1:0]  bram_din,
    output logic                   bram_en,
    output logic                   bram_we,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH:0]    wcount
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [1:0]             state_q, state_d;
    logic [ADDR_WIDTH:0]    len_q, len_d;
    logic [DECIM_WIDTH-1:0] decim_q, decim_d;
    logic [DECIM_WIDTH-1:0] dcnt_q, dcnt_d;
    logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  din_q, din_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH:0]    wcount_q, wcount_d;
    logic [ADDR_WIDTH:0]    wcount_inc;
    logic [ADDR_WIDTH:0]    len_clamp;

    assign wcount_inc = wcount_q + 1'b1;
    assign len_clamp  = (length > DEPTH) ? DEPTH : length;

    // Next-state: abort dominates, then per-state arm/trig/beat handling.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        decim_d  = decim_q;
        dcnt_d   = dcnt_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        din_d    = din_q;
        we_d     = 1'b0;
        wcount_d = wcount_q;
        if (abort) begin
            state_d  = S_IDLE;
            wcount_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state_d  = S_ARMED;
                        len_d    = len_clamp;
                        decim_d  = decim;
                        wcount_d = '0;
                    end
                end
                S_ARMED: begin
                    if (arm) begin
                        len_d    = len_clamp;
                        decim_d  = decim;
                        wcount_d = '0;
                    end else if (trig) begin
                        ptr_d   = '0;
                        dcnt_d  = '0;
                        state_d = (len_q == '0) ? S_DONE : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (s_tvalid) begin
                        if (dcnt_q == '0) begin
                            we_d     = 1'b1;
                            addr_d   = ptr_q;
                            din_d    = s_tdata;
                            ptr_d    = ptr_q + 1'b1;
                            wcount_d = wcount_inc;
                            dcnt_d   = decim_q;
                            if (wcount_inc >= len_q) begin
                                state_d = S_DONE;
                            end
                        end else begin
                            dcnt_d = dcnt_q - 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and registered BRAM write port, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            decim_q  <= '0;
            dcnt_q   <= '0;
            ptr_q    <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            we_q     <= 1'b0;
            wcount_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            decim_q  <= decim_d;
            dcnt_q   <= dcnt_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            we_q     <= we_d;
            wcount_q <= wcount_d;
        end
    end

    assign s_tready  = resetn;
    assign bram_addr = addr_q;
    assign bram_din  = din_q;
    assign bram_en   = we_q;
    assign bram_we   = we_q;
    assign busy      = (state_q == S_ARMED) || (state_q == S_CAPTURE);
    assign done      = (state_q == S_DONE);
    assign wcount    = wcount_q;

endmodule

// File: tb/tb_acq_bram_ctrl.sv
// tb_acq_bram_ctrl: directed stimulus with a write scoreboard.
// Expected BRAM writes are queued up front; a negedge monitor pops and checks.
module tb_acq_bram_ctrl;

    localparam int AW = 13;
    localparam int DW = 64;
    localparam int DCW = 8;

    logic           clk = 1'b0;
    logic           resetn;
    logic           arm, abort, trig;
    logic [AW:0]    length;
    logic [DCW-1:0] decim;
    logic [DW-1:0]  s_tdata;
    logic           s_tvalid;
    logic           s_tready;
    logic [AW-1:0]  bram_addr;
    logic [DW-1:0]  bram_din;
    logic           bram_en, bram_we;
    logic           busy, done;
    logic [AW:0]    wcount;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic vld_edge = 1'b0;

    acq_bram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DECIM_WIDTH(DCW)) dut (
        .clk(clk), .resetn(resetn), .arm(arm), .abort(abort), .trig(trig),
        .length(length), .decim(decim), .s_tdata(s_tdata),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_en(bram_en), .bram_we(bram_we),
        .busy(busy), .done(done), .wcount(wcount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) vld_edge <= s_tvalid && resetn;

    always @(negedge clk) begin
        if (bram_we === 1'b1) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write",
                         bram_addr, bram_din);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bram_addr !== e.addr || bram_din !== e.data ||
                    bram_en !== 1'b1 || done !== e.last ||
                    busy !== !e.last || !vld_edge) begin
                    n_bad++;
                    $display("FAIL write: got addr=%h data=%h en=%b done=%b busy=%b vld=%b, expected addr=%h data=%h en=1 done=%b busy=%b vld=1",
                             bram_addr, bram_din, bram_en, done, busy, vld_edge,
                             e.addr, e.data, e.last, !e.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int a, input logic [63:0] d, input logic l);
        exp_t e;
        e.addr = AW'(a);
        e.data = d;
        e.last = l;
        q.push_back(e);
    endtask

    task automatic do_arm(input int len, input int dc);
        length = (AW+1)'(len);
        decim  = DCW'(dc);
        arm    = 1'b1;
        tick();
        arm    = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; arm = 0; abort = 0; trig = 0;
        length = '0; decim = '0; s_tdata = '0; s_tvalid = 0;
        repeat (3) tick();
        chk("rst_we", 64'(bram_we), 0);
        chk("rst_en", 64'(bram_en), 0);
        chk("rst_addr", 64'(bram_addr), 0);
        chk("rst_din", bram_din, 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_wcount", 64'(wcount), 0);
        chk("rst_tready", 64'(s_tready), 0);
        resetn = 1'b1;
        tick();
        chk("tready", 64'(s_tready), 1);

        // T1: length 8, decim 0, counter from 0x100 at trig
        for (int k = 1; k <= 8; k++) push(k - 1, 64'h100 + 64'(k), k == 8);
        do_arm(8, 0);
        chk("t1_arm_busy", 64'(busy), 1);
        chk("t1_arm_done", 64'(done), 0);
        s_tvalid = 1;
        for (int c = 0; c < 9; c++) begin
            s_tdata = 64'hDEAD_0000 + 64'(c);
            tick();
        end
        trig = 1; s_tdata = 64'h100;
        tick();
        trig = 0;
        chk("t1_trig_busy", 64'(busy), 1);
        for (int k = 1; k <= 12; k++) begin
            s_tdata = 64'h100 + 64'(k);
            tick();
        end
        s_tvalid = 0;
        chk("t1_done", 64'(done), 1);
        chk("t1_busy", 64'(busy), 0);
        chk("t1_wcount", 64'(wcount), 8);
        chk("t1_sb_empty", 64'(q.size()), 0);

        // T2: length 4, decim 2 -> 0,3,6,9
        push(0, 0, 0); push(1, 3, 0); push(2, 6, 0); push(3, 9, 1);
        do_arm(4, 2);
        chk("t2_arm_done", 64'(done), 0);
        trig = 1; s_tvalid = 1; s_tdata = 64'hBEEF;
        tick();
        trig = 0;
        for (int k = 0; k < 32; k++) begin
            s_tdata = 64'(k);
            tick();
        end
        s_tvalid = 0;
        chk("t2_done", 64'(done), 1);
        chk("t2_wcount", 64'(wcount), 4);
        chk("t2_sb_empty", 64'(q.size()), 0);

        // T3: gapped valid, 1 on / 2 off, length 5
        for (int k = 0; k < 5; k++) push(k, 64'h200 + 64'(k), k == 4);
        do_arm(5, 0);
        trig = 1;
        tick();
        trig = 0;
        for (int c = 0; c < 24; c++) begin
            s_tvalid = (c % 3 == 0);
            s_tdata  = (c % 3 == 0) ? 64'h200 + 64'(c / 3) : 64'hBAD;
            tick();
        end
        s_tvalid = 0;
        chk("t3_done", 64'(done), 1);
        chk("t3_wcount", 64'(wcount), 5);
        chk("t3_sb_empty", 64'(q.size()), 0);

        // T4: length 0x3FFF clamps to 8192
        for (int k = 0; k < 8192; k++) push(k, 64'(k) ^ 64'hA5A5_0000_0000, k == 8191);
        do_arm(16'h3FFF, 0);
        trig = 1; s_tvalid = 1; s_tdata = 64'hFFFF;
        tick();
        trig = 0;
        for (int k = 0; k < 8200; k++) begin
            s_tdata = 64'(k) ^ 64'hA5A5_0000_0000;
            tick();
        end
        s_tvalid = 0;
        chk("t4_done", 64'(done), 1);
        chk("t4_wcount", 64'(wcount), 8192);
        chk("t4_last_addr", 64'(bram_addr), 64'h1FFF);
        chk("t4_sb_empty", 64'(q.size()), 0);

        // T5a: abort after 3 of 10 writes
        for (int k = 0; k < 3; k++) push(k, 64'h500 + 64'(k), 0);
        do_arm(10, 0);
        trig = 1; s_tvalid = 1;
        tick();
        trig = 0;
        for (int k = 0; k < 3; k++) begin
            s_tdata = 64'h500 + 64'(k);
            tick();
        end
        abort = 1; s_tdata = 64'h503;
        tick();
        abort = 0;
        chk("t5_abort_we", 64'(bram_we), 0);
        for (int k = 4; k < 10; k++) begin
            s_tdata = 64'h500 + 64'(k);
            tick();
        end
        chk("t5_busy", 64'(busy), 0);
        chk("t5_done", 64'(done), 0);
        chk("t5_wcount", 64'(wcount), 0);
        trig = 1;
        tick();
        trig = 0;
        repeat (4) tick();
        s_tvalid = 0;
        chk("t5_idle_trig_busy", 64'(busy), 0);
        chk("t5_sb_empty", 64'(q.size()), 0);

        // T5b: reset mid-capture
        for (int k = 0; k < 3; k++) push(k, 64'h600 + 64'(k), 0);
        do_arm(10, 0);
        trig = 1; s_tvalid = 1;
        tick();
        trig = 0;
        for (int k = 0; k < 3; k++) begin
            s_tdata = 64'h600 + 64'(k);
            tick();
        end
        resetn = 0; s_tdata = 64'h603;
        tick();
        chk("t5r_we", 64'(bram_we), 0);
        chk("t5r_tready", 64'(s_tready), 0);
        resetn = 1;
        for (int k = 4; k < 10; k++) begin
            s_tdata = 64'h600 + 64'(k);
            tick();
        end
        s_tvalid = 0;
        chk("t5r_busy", 64'(busy), 0);
        chk("t5r_done", 64'(done), 0);
        chk("t5r_wcount", 64'(wcount), 0);
        chk("t5r_sb_empty", 64'(q.size()), 0);

        // T6: arm+trig together, trig in DONE/IDLE, length 0
        length = 2; decim = 0; arm = 1; trig = 1; s_tvalid = 1;
        s_tdata = 64'h3FF;
        tick();
        arm = 0; trig = 0;
        repeat (4) tick();
        chk("t6_armed_busy", 64'(busy), 1);
        chk("t6_armed_wcount", 64'(wcount), 0);
        push(0, 64'h301, 0); push(1, 64'h302, 1);
        trig = 1; s_tdata = 64'h300;
        tick();
        trig = 0;
        for (int k = 1; k <= 4; k++) begin
            s_tdata = 64'h300 + 64'(k);
            tick();
        end
        chk("t6_done", 64'(done), 1);
        trig = 1;
        tick();
        trig = 0;
        repeat (3) tick();
        chk("t6_done_trig", 64'(done), 1);
        chk("t6_done_wcount", 64'(wcount), 2);
        s_tvalid = 0;
        do_arm(0, 0);
        chk("t6_len0_busy", 64'(busy), 1);
        chk("t6_len0_arm_done", 64'(done), 0);
        trig = 1;
        tick();
        trig = 0;
        chk("t6_len0_done", 64'(done), 1);
        chk("t6_len0_wcount", 64'(wcount), 0);
        repeat (2) tick();
        chk("t6_sb_empty", 64'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
